rr_plogb_beat_packer: RTL and testbench
=======================================

Name: rr_plogb_beat_packer

Overview:
- Sits directly downstream of the unpack-to-pack logging-bus stage. Consumes its packed logging bus: one variable-length record per transfer, made of any_valid, data, len, and the logb_valid/loge_valid bitmaps.
- Serializes records back-to-back, LSB-first, into fixed BEAT_WIDTH beats for the log writer (DMA/PCIe path).
- Supports an explicit flush that zero-pads and emits the partial tail beat.

Parameters:
- FULL_WIDTH, 1000: max record payload bits; equals the upstream bus FULL_WIDTH.
- LOGB_CHANNEL_CNT, 8: logb bitmap width.
- LOGE_CHANNEL_CNT, 4: loge bitmap width.
- BEAT_WIDTH, 512: output beat width.
- LEN_W, $clog2(FULL_WIDTH+1): width of in_len (localparam).
- HDR_W, LOGB_CHANNEL_CNT+LOGE_CHANNEL_CNT: record header width (localparam).
- ACC_W, BEAT_WIDTH+HDR_W+FULL_WIDTH: accumulator width (localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  record valid (upstream any_valid)
- in_data  in  FULL_WIDTH  payload; bits [in_len-1:0] meaningful
- in_len  in  LEN_W  payload bit count
- in_logb_valid  in  LOGB_CHANNEL_CNT  logb bitmap
- in_loge_valid  in  LOGE_CHANNEL_CNT  loge bitmap
- in_ready  out  1  record accepted when in_valid && in_ready
- out_valid  out  1  beat valid
- out_data  out  BEAT_WIDTH  beat payload
- out_last  out  1  beat is the padded flush tail
- out_ready  in  1  downstream accept
- flush_req  in  1  level; request drain and pad
- flush_done  out  1  one-cycle pulse when flush completes
- fill_level  out  $clog2(ACC_W+1)  current accumulator bit count

Behaviour:
- Reset: fill=0, accumulator=0, state=RUN. in_ready=1 (registered-derived). out_valid=0, out_last=0, flush_done=0, counters=0.
- Record format, LSB-first:
  - bits [LOGB-1:0] = in_logb_valid
  - next LOGE bits = in_loge_valid
  - next in_len bits = in_data[in_len-1:0]
  - Record length = HDR_W + in_len. Bits of in_data above in_len are masked to zero before insertion.
- Accept:
  - in_ready = (state==RUN) && (fill < BEAT_WIDTH). No combinational path from out_ready or in_valid.
  - On accept, the record is ORed into the accumulator at bit offset fill; fill += HDR_W+in_len.
- Emit:
  - out_valid = fill >= BEAT_WIDTH, or state==FLUSH_PAD with fill>0.
  - out_data = acc[BEAT_WIDTH-1:0], taken directly from the register.
  - On out_valid && out_ready: acc >>= BEAT_WIDTH, fill -= min(fill, BEAT_WIDTH).
  - out_data/out_last stay stable while out_valid && !out_ready.
- Accept and emit in the same cycle: the shift is applied first, then the record is inserted at the post-shift fill. New fill = fill - BEAT_WIDTH + rec_len.
- Worst case: fill = BEAT_WIDTH-1+HDR_W+FULL_WIDTH <= ACC_W, so no overflow. Records longer than a beat drain over multiple cycles with in_ready=0.
- in_len==0 with in_valid: header-only record (loge-only events); fill += HDR_W.
- FSM:
  - RUN -> FLUSH_DRAIN on flush_req. in_ready drops the same cycle the state registers.
  - FLUSH_DRAIN: emit full beats. When fill < BEAT_WIDTH: go to FLUSH_PAD if fill>0, else FLUSH_ACK.
  - FLUSH_PAD: out_valid=1, out_last=1, upper bits zero. On handshake, fill=0 -> FLUSH_ACK.
  - FLUSH_ACK: flush_done=1 for one cycle. Go to FLUSH_HOLD if flush_req is still high, else RUN.
  - FLUSH_HOLD: wait for flush_req low -> RUN.
- A flush with an empty accumulator yields flush_done 2 cycles after flush_req, with no beat.
- flush_req dropping mid-flush does not abort the flush.
- rst mid-operation discards the accumulator; no beat is emitted.

Optional Feature:
- Macro: RR_PACKER_STATS_EN.
- Defined: adds outputs stat_records[31:0] (accepted records), stat_beats[31:0] (emitted beats) and stat_stall_cycles[31:0] (cycles with out_valid && !out_ready). All wrap modulo 2^32; cleared by rst.
- Undefined: these ports are absent and there is no counter logic.

Test Plan:
Bench configuration for all scenarios: LOGB=2, LOGE=1, FULL_WIDTH=24, BEAT_WIDTH=32.
- Back-to-back: three records {logb=2'b01, loge=0, len=8, data=8'hA5}, each 11 bits = 0x529 -> one beat 0x4A694D29, out_last=0; fill_level=1.
- Flush tail: continue from the previous scenario, raise flush_req -> beat 0x00000001 with out_last=1; flush_done pulses once; in_ready stays 0 until flush_req falls and state returns to RUN.
- Backpressure: hold out_ready=0 for 10 cycles with a beat pending -> out_data stable; in_ready=0 once fill>=32; no data lost or duplicated (scoreboard); stats stall count=10 when enabled.
- Oversize record: len=24, logb=2'b11, from fill=31 -> fill=58; one beat, then fill=26; in_ready=0 only during the cycle fill>=32.
- Empty flush and header-only record: flush at fill=0 -> no beat, flush_done 2 cycles later. Then a len=0 record with loge=1 -> fill=3, bits 3'b100.
- Reset mid-stream: rst at fill=20 -> next cycle out_valid=0, fill_level=0, in_ready=1; stream resumes cleanly.

Source files
------------

// File: rtl/rr_plogb_beat_packer.sv
// Packs variable-length logging-bus records LSB-first into fixed-width beats, with flush/pad.
// Optional statistics counters are enabled by defining RR_PACKER_STATS_EN.
module rr_plogb_beat_packer #(
   parameter int FULL_WIDTH       = 1000,
   parameter int LOGB_CHANNEL_CNT = 8,
   parameter int LOGE_CHANNEL_CNT = 4,
   parameter int BEAT_WIDTH       = 512,
   localparam int LEN_W  = $clog2(FULL_WIDTH + 1),
   localparam int HDR_W  = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
   localparam int ACC_W  = BEAT_WIDTH + HDR_W + FULL_WIDTH,
   localparam int FILL_W = $clog2(ACC_W + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [FULL_WIDTH-1:0]       in_data,
   input  logic [LEN_W-1:0]            in_len,
   input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
   input  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic [BEAT_WIDTH-1:0]       out_data,
   output logic                        out_last,
   input  logic                        out_ready,
   input  logic                        flush_req,
   output logic                        flush_done,
   output logic [FILL_W-1:0]           fill_level
`ifdef RR_PACKER_STATS_EN
   ,
   output logic [31:0]                 stat_records,
   output logic [31:0]                 stat_beats,
   output logic [31:0]                 stat_stall_cycles
`endif
);

   localparam logic [FILL_W-1:0] BEAT_FILL = FILL_W'(BEAT_WIDTH);
   localparam logic [FILL_W-1:0] HDR_FILL  = FILL_W'(HDR_W);
   localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(FULL_WIDTH);

   typedef enum logic [2:0] {
      ST_RUN         = 3'd0,
      ST_FLUSH_DRAIN = 3'd1,
      ST_FLUSH_PAD   = 3'd2,
      ST_FLUSH_ACK   = 3'd3,
      ST_FLUSH_HOLD  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [FILL_W-1:0]   fill_q, fill_d;

   logic [LEN_W-1:0]      len_c_s;
   logic [FULL_WIDTH-1:0] data_mask_s;
   logic [ACC_W-1:0]      rec_ext_s;
   logic [FILL_W-1:0]     rec_len_s;
   logic [ACC_W-1:0]      acc_shift_s;
   logic [FILL_W-1:0]     fill_shift_s;
   logic                  in_ready_s;
   logic                  out_valid_s;
   logic                  in_fire_s;
   logic                  out_fire_s;

   // Handshake qualifiers depend only on registered state so there is no input-to-output path.
   always_comb begin
      in_ready_s  = (state_q == ST_RUN) && (fill_q < BEAT_FILL);
      out_valid_s = (fill_q >= BEAT_FILL) ||
                    ((state_q == ST_FLUSH_PAD) && (fill_q != {FILL_W{1'b0}}));
      in_fire_s   = in_valid && in_ready_s;
      out_fire_s  = out_valid_s && out_ready;
   end

   // Record formation: header bitmaps in the low bits, then the length-masked payload.
   always_comb begin
      if (in_len > MAX_LEN) begin
         len_c_s = MAX_LEN;
      end else begin
         len_c_s = in_len;
      end
      data_mask_s = ~({FULL_WIDTH{1'b1}} << len_c_s);
      rec_ext_s   = ACC_W'({in_data & data_mask_s, in_loge_valid, in_logb_valid});
      rec_len_s   = HDR_FILL + FILL_W'(len_c_s);
   end

   // Datapath: drain a beat first, then insert any accepted record at the post-drain fill.
   always_comb begin
      acc_shift_s  = acc_q;
      fill_shift_s = fill_q;
      acc_d        = acc_q;
      fill_d       = fill_q;
      if (out_fire_s) begin
         acc_shift_s = acc_q >> BEAT_WIDTH;
         if (fill_q >= BEAT_FILL) begin
            fill_shift_s = fill_q - BEAT_FILL;
         end else begin
            fill_shift_s = {FILL_W{1'b0}};
         end
      end else begin
         acc_shift_s  = acc_q;
         fill_shift_s = fill_q;
      end
      if (in_fire_s) begin
         acc_d  = acc_shift_s | (rec_ext_s << fill_shift_s);
         fill_d = fill_shift_s + rec_len_s;
      end else begin
         acc_d  = acc_shift_s;
         fill_d = fill_shift_s;
      end
   end

   // Flush sequencing; a flush in progress always completes even if flush_req drops.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (flush_req) begin
               state_d = ST_FLUSH_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH_DRAIN: begin
            if (fill_q >= BEAT_FILL) begin
               state_d = ST_FLUSH_DRAIN;
            end else if (fill_q != {FILL_W{1'b0}}) begin
               state_d = ST_FLUSH_PAD;
            end else begin
               state_d = ST_FLUSH_ACK;
            end
         end
         ST_FLUSH_PAD: begin
            if (out_fire_s) begin
               state_d = ST_FLUSH_ACK;
            end else begin
               state_d = ST_FLUSH_PAD;
            end
         end
         ST_FLUSH_ACK: begin
            if (flush_req) begin
               state_d = ST_FLUSH_HOLD;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH_HOLD: begin
            if (flush_req) begin
               state_d = ST_FLUSH_HOLD;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State, accumulator and fill registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         acc_q   <= {ACC_W{1'b0}};
         fill_q  <= {FILL_W{1'b0}};
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
      end
   end

   assign in_ready   = in_ready_s;
   assign out_valid  = out_valid_s;
   assign out_data   = acc_q[BEAT_WIDTH-1:0];
   assign out_last   = (state_q == ST_FLUSH_PAD);
   assign flush_done = (state_q == ST_FLUSH_ACK);
   assign fill_level = fill_q;

`ifdef RR_PACKER_STATS_EN
   logic [31:0] stat_records_q, stat_records_d;
   logic [31:0] stat_beats_q, stat_beats_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Free-running statistics, wrapping modulo 2^32.
   always_comb begin
      stat_records_d = stat_records_q;
      stat_beats_d   = stat_beats_q;
      stat_stall_d   = stat_stall_q;
      if (in_fire_s) begin
         stat_records_d = stat_records_q + 32'd1;
      end else begin
         stat_records_d = stat_records_q;
      end
      if (out_fire_s) begin
         stat_beats_d = stat_beats_q + 32'd1;
      end else begin
         stat_beats_d = stat_beats_q;
      end
      if (out_valid_s && !out_ready) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end else begin
         stat_stall_d = stat_stall_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_records_q <= 32'd0;
         stat_beats_q   <= 32'd0;
         stat_stall_q   <= 32'd0;
      end else begin
         stat_records_q <= stat_records_d;
         stat_beats_q   <= stat_beats_d;
         stat_stall_q   <= stat_stall_d;
      end
   end

   assign stat_records      = stat_records_q;
   assign stat_beats        = stat_beats_q;
   assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_rr_plogb_beat_packer.sv
// Directed bench for rr_plogb_beat_packer (LOGB=2, LOGE=1, FULL_WIDTH=24, BEAT_WIDTH=32).
module tb_rr_plogb_beat_packer;
   localparam int FW = 24;
   localparam int LB = 2;
   localparam int LE = 1;
   localparam int BW = 32;
   localparam int LEN_W = 5;
   localparam int FILL_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [FW-1:0]     in_data;
   logic [LEN_W-1:0]  in_len;
   logic [LB-1:0]     in_logb_valid;
   logic [LE-1:0]     in_loge_valid;
   logic              in_ready;
   logic              out_valid;
   logic [BW-1:0]     out_data;
   logic              out_last;
   logic              out_ready;
   logic              flush_req;
   logic              flush_done;
   logic [FILL_W-1:0] fill_level;
`ifdef RR_PACKER_STATS_EN
   logic [31:0]       stat_records;
   logic [31:0]       stat_beats;
   logic [31:0]       stat_stall_cycles;
`endif

   int checks = 0;
   int errors = 0;
   bit model_q[$];

   rr_plogb_beat_packer #(
      .FULL_WIDTH(FW), .LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .BEAT_WIDTH(BW)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_len(in_len),
      .in_logb_valid(in_logb_valid), .in_loge_valid(in_loge_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .flush_req(flush_req), .flush_done(flush_done), .fill_level(fill_level)
`ifdef RR_PACKER_STATS_EN
      , .stat_records(stat_records), .stat_beats(stat_beats), .stat_stall_cycles(stat_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard the handshakes of the current cycle, then advance to just after the next edge.
   task automatic tick();
      logic [BW-1:0] exp_beat;
      logic          exp_last;
      if (rst) begin
         model_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            exp_last = (model_q.size() < BW);
            for (int i = 0; i < BW; i++)
               exp_beat[i] = (model_q.size() > 0) ? model_q.pop_front() : 1'b0;
            chk("beat_data", 64'(out_data), 64'(exp_beat));
            chk("beat_last", 64'(out_last), 64'(exp_last));
         end
         if (in_valid && in_ready) begin
            for (int i = 0; i < LB; i++) model_q.push_back(in_logb_valid[i]);
            for (int i = 0; i < LE; i++) model_q.push_back(in_loge_valid[i]);
            for (int i = 0; i < int'(in_len); i++) model_q.push_back(in_data[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [LB-1:0] b, input logic [LE-1:0] e,
                       input logic [LEN_W-1:0] l, input logic [FW-1:0] d);
      logic accepted;
      in_logb_valid = b;
      in_loge_valid = e;
      in_len        = l;
      in_data       = d;
      in_valid      = 1'b1;
      accepted      = 1'b0;
      for (int n = 0; n < 20 && !accepted; n++) begin
         if (in_ready) accepted = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("send_accept", 64'(accepted), 64'd1);
   endtask

   task automatic do_flush();
      logic seen;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         if (flush_done) seen = 1'b1;
         else tick();
      end
      chk("flush_done_seen", 64'(seen), 64'd1);
      tick();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0;
      in_logb_valid = '0; in_loge_valid = '0; out_ready = 1'b0; flush_req = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_flush_done", 64'(flush_done), 64'd0);
      chk("rst_fill", 64'(fill_level), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      // Back-to-back: junk above len must be masked off
      out_ready = 1'b1;
      repeat (3) send(2'b01, 1'b0, 5'd8, 24'hFFFFA5);
      chk("b2b_fill33", 64'(fill_level), 64'd33);
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_data", 64'(out_data), 64'h4A694D29);
      chk("b2b_last", 64'(out_last), 64'd0);
      chk("b2b_not_ready", 64'(in_ready), 64'd0);
      tick();
      chk("b2b_fill1", 64'(fill_level), 64'd1);
      chk("b2b_valid_low", 64'(out_valid), 64'd0);

      // Flush tail with flush_req held high
      flush_req = 1'b1;
      tick();
      chk("fl_drain_ready", 64'(in_ready), 64'd0);
      chk("fl_drain_valid", 64'(out_valid), 64'd0);
      tick();
      chk("fl_pad_valid", 64'(out_valid), 64'd1);
      chk("fl_pad_last", 64'(out_last), 64'd1);
      chk("fl_pad_data", 64'(out_data), 64'h00000001);
      tick();
      chk("fl_ack_done", 64'(flush_done), 64'd1);
      chk("fl_ack_ready", 64'(in_ready), 64'd0);
      chk("fl_ack_valid", 64'(out_valid), 64'd0);
      tick();
      chk("fl_hold_done", 64'(flush_done), 64'd0);
      chk("fl_hold_ready", 64'(in_ready), 64'd0);
      tick();
      chk("fl_hold_ready2", 64'(in_ready), 64'd0);
      flush_req = 1'b0;
      tick();
      chk("fl_run_ready", 64'(in_ready), 64'd1);
      chk("fl_run_fill", 64'(fill_level), 64'd0);

      // Backpressure for 10 cycles with a beat pending
      out_ready = 1'b0;
      repeat (3) send(2'b01, 1'b0, 5'd8, 24'h0000A5);
      for (int i = 0; i < 10; i++) begin
         chk("bp_data", 64'(out_data), 64'h4A694D29);
         chk("bp_ready", 64'(in_ready), 64'd0);
         tick();
      end
      chk("bp_data_end", 64'(out_data), 64'h4A694D29);
      chk("bp_valid_end", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_fill1", 64'(fill_level), 64'd1);
`ifdef RR_PACKER_STATS_EN
      chk("stat_records", 64'(stat_records), 64'd6);
      chk("stat_beats", 64'(stat_beats), 64'd3);
      chk("stat_stall", 64'(stat_stall_cycles), 64'd10);
`endif
      do_flush();
      chk("bp_flushed_fill", 64'(fill_level), 64'd0);

      // Oversize record crossing a beat from fill=31
      send(2'b11, 1'b0, 5'd24, 24'h123456);
      send(2'b00, 1'b1, 5'd1, 24'hFFFFFF);
      chk("ov_fill31", 64'(fill_level), 64'd31);
      chk("ov_ready31", 64'(in_ready), 64'd1);
      send(2'b11, 1'b0, 5'd24, 24'hABCDEF);
      chk("ov_fill58", 64'(fill_level), 64'd58);
      chk("ov_not_ready", 64'(in_ready), 64'd0);
      chk("ov_data", 64'(out_data), 64'hE091A2B3);
      tick();
      chk("ov_fill26", 64'(fill_level), 64'd26);
      chk("ov_ready26", 64'(in_ready), 64'd1);
      chk("ov_rest", 64'(out_data), 64'h02AF37BD);
      do_flush();

      // Empty flush, then header-only record
      flush_req = 1'b1;
      tick();
      chk("ef_done_c1", 64'(flush_done), 64'd0);
      flush_req = 1'b0;
      tick();
      chk("ef_done_c2", 64'(flush_done), 64'd1);
      chk("ef_no_beat", 64'(out_valid), 64'd0);
      tick();
      chk("ef_done_c3", 64'(flush_done), 64'd0);
      chk("ef_ready", 64'(in_ready), 64'd1);
      send(2'b00, 1'b1, 5'd0, 24'hFFFFFF);
      chk("hdr_fill3", 64'(fill_level), 64'd3);
      chk("hdr_bits", 64'(out_data), 64'h00000004);

      // Reset mid-stream at fill=20
      send(2'b01, 1'b0, 5'd14, 24'h003FFF);
      chk("rs_fill20", 64'(fill_level), 64'd20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_valid", 64'(out_valid), 64'd0);
      chk("rs_fill", 64'(fill_level), 64'd0);
      chk("rs_ready", 64'(in_ready), 64'd1);
      repeat (3) send(2'b01, 1'b0, 5'd8, 24'h0000A5);
      chk("rs_resume_data", 64'(out_data), 64'h4A694D29);
      tick();
      chk("rs_resume_fill", 64'(fill_level), 64'd1);
      do_flush();
      chk("final_fill", 64'(fill_level), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
